// File: rtl/iccm_arbiter.sv
// iccm_arbiter: two-port (fetch/loader) arbiter onto a single-cycle-latency instruction memory
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   f_req_i/f_addr_i                  fetch read request
//   f_gnt_o/f_rvalid_o/f_rdata_o      fetch grant and read response
//   l_req_i/l_we_i/l_addr_i/l_wdata_i/l_wmask_i  loader read/write request
//   l_gnt_o/l_rvalid_o/l_rdata_o      loader grant and read response
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_wmask_o  memory command
//   mem_rdata_i/mem_rvalid_i          memory read response (one cycle after the command)
//   resp_err_o                        sticky flag: response arrived with no read outstanding
module iccm_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    f_req_i,
   input  logic [ADDR_WIDTH-1:0]   f_addr_i,
   output logic                    f_gnt_o,
   output logic                    f_rvalid_o,
   output logic [DATA_WIDTH-1:0]   f_rdata_o,
   input  logic                    l_req_i,
   input  logic                    l_we_i,
   input  logic [ADDR_WIDTH-1:0]   l_addr_i,
   input  logic [DATA_WIDTH-1:0]   l_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] l_wmask_i,
   output logic                    l_gnt_o,
   output logic                    l_rvalid_o,
   output logic [DATA_WIDTH-1:0]   l_rdata_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   input  logic                    mem_rvalid_i,
   output logic                    resp_err_o
);
   logic [3:0] starve_cnt;
   logic       pend_valid;
   logic       pend_owner;
   logic       rst_q;
   logic       at_max;
   logic       rsp;
   logic       rd_gnt;
   // Loader has priority; fetch wins only once it has stalled MAX_WAIT cycles in a row.
   assign at_max      = starve_cnt == 4'(MAX_WAIT);
   assign f_gnt_o     = !rst_i && f_req_i && (!l_req_i || at_max);
   assign l_gnt_o     = !rst_i && l_req_i && !(f_req_i && at_max);
   assign mem_req_o   = f_gnt_o | l_gnt_o;
   assign mem_we_o    = l_gnt_o & l_we_i;
   assign mem_addr_o  = f_gnt_o ? f_addr_i : l_gnt_o ? l_addr_i : '0;
   assign mem_wdata_o = l_gnt_o ? l_wdata_i : '0;
   assign mem_wmask_o = l_gnt_o ? l_wmask_i : '0;
   assign rd_gnt      = mem_req_o && !mem_we_o;
   assign rsp         = !rst_i && mem_rvalid_i && pend_valid;
   assign f_rvalid_o  = rsp && !pend_owner;
   assign l_rvalid_o  = rsp && pend_owner;
   assign f_rdata_o   = f_rvalid_o ? mem_rdata_i : '0;
   assign l_rdata_o   = l_rvalid_o ? mem_rdata_i : '0;
   always_ff @(posedge clk_i) begin
      rst_q <= rst_i;
      if (rst_i) begin
         starve_cnt <= '0;
         pend_valid <= 1'b0;
         pend_owner <= 1'b0;
         resp_err_o <= 1'b0;
      end else begin
         starve_cnt <= (!f_req_i || f_gnt_o) ? '0 : at_max ? starve_cnt : starve_cnt + 4'd1;
         pend_valid <= rd_gnt;
         if (rd_gnt) pend_owner <= l_gnt_o;
         // A response for a read discarded by reset may land in the first cycle after release.
         if (mem_rvalid_i && !pend_valid && !rst_q) resp_err_o <= 1'b1;
      end
   end
endmodule
